// File: rtl/lcb_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcb_rx_pkg
// Description : Shared widths, default sync marker and state encoding for the
//               LCB receive framer.
// Revision    : 1.0 - initial release
// ============================================================================
package lcb_rx_pkg;

    localparam int c_byte_w  = 8;
    localparam int c_idx_w   = 5;
    localparam int c_rq_w    = 5;
    localparam int c_state_w = 2;

    localparam logic [c_byte_w-1:0] c_sync_byte_dflt = 8'hA5;

    typedef logic [c_state_w-1:0] state_t;

    localparam state_t c_st_idle    = 2'd0;
    localparam state_t c_st_payload = 2'd1;
    localparam state_t c_st_check   = 2'd2;
    localparam state_t c_st_drain   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/lcb_rx_gap_timer.sv
`default_nettype none
// ============================================================================
// Module      : lcb_rx_gap_timer
// Description : Inter-byte gap watchdog. Counts enabled cycles since the last
//               restart and flags the cycle in which GAP_CYCLES is reached.
// Revision    : 1.0 - initial release
// ============================================================================
module lcb_rx_gap_timer #(
    parameter int GAP_CYCLES = 400
) (
    input  logic clk,
    input  logic reset,
    input  logic i_restart,
    input  logic i_enable,
    output logic o_expire
);

    localparam int                 c_cnt_w = $clog2(GAP_CYCLES);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(GAP_CYCLES - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Cycle counter: cleared on restart, parks at its terminal value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_restart) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != c_last)) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    // Expiry is the cycle whose closing edge would complete GAP_CYCLES idle cycles.
    assign o_expire = i_enable && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/lcb_rx_framer.sv
`default_nettype none
// ============================================================================
// Module      : lcb_rx_framer
// Description : Hunts for the sync byte in the UART byte stream, buffers a
//               fixed-length payload, validates it and drains verified bytes
//               downstream tagged with the request number latched at sync.
//               Build option LCB_RX_CHKSUM_EN adds a trailing checksum byte
//               that must bring the modulo-256 payload sum to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module lcb_rx_framer
    import lcb_rx_pkg::*;
#(
    parameter logic [c_byte_w-1:0] SYNC_BYTE     = c_sync_byte_dflt,
    parameter int                  PAYLOAD_BYTES = 12,
    parameter int                  GAP_CYCLES    = 400
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [c_byte_w-1:0] iData,
    input  logic                iValid,
    input  logic [c_rq_w-1:0]   iRqNum,
    output logic [c_byte_w-1:0] oData,
    output logic [c_idx_w-1:0]  oIndex,
    output logic [c_rq_w-1:0]   oRqNum,
    output logic                oValid,
    input  logic                iReady,
    output logic                oBusy,
    output logic                oPktDone,
    output logic                oErr,
    output logic [7:0]          oErrCnt
);

    localparam int                 c_buf_aw   = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(PAYLOAD_BYTES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_idx_w-1:0]  r_idx;
    logic [c_rq_w-1:0]   r_rq;
    logic                r_pkt_done;
    logic                r_err;
    logic [7:0]          r_err_cnt;
    logic [c_byte_w-1:0] r_buf [PAYLOAD_BYTES];

    logic w_sync;
    logic w_store;
    logic w_xfer;
    logic w_last;
    logic w_err_evt;
    logic w_done;
    logic w_timer_en;
    logic w_timer_restart;
    logic w_expire;

`ifdef LCB_RX_CHKSUM_EN
    logic [c_byte_w-1:0] r_sum;
    logic [c_byte_w-1:0] w_sum_nxt;

    assign w_sum_nxt = r_sum + iData;
`endif

    // One index serves as the write pointer while filling and the read pointer while draining.
    assign w_last = (r_idx == c_last_idx);
    assign w_xfer = (r_state == c_st_drain) && iReady;

    // The timer only runs between bytes of a packet; any incoming byte restarts it.
    assign w_timer_en      = (r_state == c_st_payload) || (r_state == c_st_check);
    assign w_timer_restart = iValid || !w_timer_en;

    lcb_rx_gap_timer #(
        .GAP_CYCLES (GAP_CYCLES)
    ) u_gap_timer (
        .clk       (clk),
        .reset     (reset),
        .i_restart (w_timer_restart),
        .i_enable  (w_timer_en),
        .o_expire  (w_expire)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-cycle control strobes; a byte in the expiry cycle beats the timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_sync      = 1'b0;
        w_store     = 1'b0;
        w_err_evt   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (iValid && (iData == SYNC_BYTE)) begin
                    w_sync      = 1'b1;
                    w_state_nxt = c_st_payload;
                end
            end
            c_st_payload: begin
                if (iValid) begin
                    w_store = 1'b1;
                    if (w_last) begin
`ifdef LCB_RX_CHKSUM_EN
                        w_state_nxt = c_st_check;
`else
                        w_state_nxt = c_st_drain;
`endif
                    end
                end else if (w_expire) begin
                    w_err_evt   = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
`ifdef LCB_RX_CHKSUM_EN
            c_st_check: begin
                if (iValid) begin
                    if (w_sum_nxt == '0) begin
                        w_state_nxt = c_st_drain;
                    end else begin
                        w_err_evt   = 1'b1;
                        w_state_nxt = c_st_idle;
                    end
                end else if (w_expire) begin
                    w_err_evt   = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
`endif
            c_st_drain: begin
                // Bytes arriving while draining are lost; flag them as overrun.
                if (iValid) begin
                    w_err_evt = 1'b1;
                end
                if (w_xfer && w_last) begin
                    w_done      = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Index, request tag, status pulses and saturating error counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx      <= '0;
            r_rq       <= '0;
            r_pkt_done <= 1'b0;
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_pkt_done <= w_done;
            r_err      <= w_err_evt;
            if (w_err_evt && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
            if (w_sync) begin
                r_rq  <= iRqNum;
                r_idx <= '0;
            end else if (w_store || w_xfer) begin
                r_idx <= w_last ? '0 : r_idx + c_idx_w'(1);
            end else if (w_state_nxt == c_st_idle) begin
                r_idx <= '0;
            end
        end
    end

`ifdef LCB_RX_CHKSUM_EN
    // Running modulo-256 payload sum, cleared at sync.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sum <= '0;
        end else if (w_sync) begin
            r_sum <= '0;
        end else if (w_store) begin
            r_sum <= w_sum_nxt;
        end
    end
`endif

    // Payload buffer; contents need no reset since they are only read while draining.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_buf[r_idx[c_buf_aw-1:0]] <= iData;
        end
    end

    assign oValid   = (r_state == c_st_drain);
    assign oBusy    = (r_state != c_st_idle);
    assign oData    = oValid ? r_buf[r_idx[c_buf_aw-1:0]] : '0;
    assign oIndex   = r_idx;
    assign oRqNum   = r_rq;
    assign oPktDone = r_pkt_done;
    assign oErr     = r_err;
    assign oErrCnt  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lcb_rx_framer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_lcb_rx_framer
// Description : Scoreboard bench for lcb_rx_framer. Stimulus pushes expected
//               transfers, packet completions and error events; a monitor
//               pops and compares them as the framer presents outputs.
//               Follows LCB_RX_CHKSUM_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcb_rx_framer;

    localparam int         P    = 12;
    localparam int         GAP  = 32;
    localparam logic [7:0] SYNC = 8'hA5;

    localparam int F_OK  = 0;
    localparam int F_TO  = 1;
    localparam int F_BAD = 2;
    localparam int F_OVR = 3;

    logic       clk;
    logic       reset;
    logic [7:0] iData;
    logic       iValid;
    logic [4:0] iRqNum;
    logic [7:0] oData;
    logic [4:0] oIndex;
    logic [4:0] oRqNum;
    logic       oValid;
    logic       iReady;
    logic       oBusy;
    logic       oPktDone;
    logic       oErr;
    logic [7:0] oErrCnt;

    lcb_rx_framer #(
        .SYNC_BYTE     (SYNC),
        .PAYLOAD_BYTES (P),
        .GAP_CYCLES    (GAP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .iData    (iData),
        .iValid   (iValid),
        .iRqNum   (iRqNum),
        .oData    (oData),
        .oIndex   (oIndex),
        .oRqNum   (oRqNum),
        .oValid   (oValid),
        .iReady   (iReady),
        .oBusy    (oBusy),
        .oPktDone (oPktDone),
        .oErr     (oErr),
        .oErrCnt  (oErrCnt)
    );

    typedef struct {
        logic [7:0] data;
        logic [4:0] idx;
        logic [4:0] rq;
    } xfer_t;

    xfer_t      q_xfer[$];
    int         q_start[$];
    int         q_err_cyc[$];
    int         q_err_cnt[$];
    int         done_pending = 0;
    int         model_errcnt = 0;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         rdy_mode = 0;
    logic [7:0] pkt [P];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_err(int c);
        if (model_errcnt < 255) model_errcnt++;
        q_err_cyc.push_back(c);
        q_err_cnt.push_back(model_errcnt);
    endfunction

    function automatic int gap_len(bit rnd);
        if (!rnd) return 1;
        if ($urandom_range(0, 9) == 0) return GAP;
        return $urandom_range(1, 4);
    endfunction

    task automatic idle(int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    // Byte driven in cycle d is sampled by the framer at the edge that starts cycle d+1.
    task automatic drive_byte(input logic [7:0] b, output int d);
        iData  = b;
        iValid = 1'b1;
        d      = cyc;
        @(posedge clk);
        #1;
        iValid = 1'b0;
        iData  = 8'($urandom);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((q_xfer.size() != 0 || oValid) && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 2000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d transfers still pending after %0d cycles", q_xfer.size(), t);
        end
        idle(1);
    endtask

    task automatic send_noise();
        int d;
        logic [7:0] b;
        repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom);
            if (b == SYNC) b = 8'h5A;
            drive_byte(b, d);
        end
    endtask

    // Reference: gap <= GAP is fine, no byte for GAP cycles errors one cycle later,
    // checksum must zero the byte sum, good packets emit P transfers then one done pulse.
    task automatic send_packet(input int fault, input int cut, input bit rnd, input logic [4:0] rq);
        int d;
`ifdef LCB_RX_CHKSUM_EN
        logic [7:0] sum;
        logic [7:0] ck;
        sum = 8'h00;
`endif
        iRqNum = rq;
        drive_byte(SYNC, d);
        chk("busy_after_sync", oBusy, 1);
        iRqNum = 5'($urandom);
        for (int i = 0; i < P; i++) begin
            if (fault == F_TO && i == cut) begin
                push_err(d + GAP + 1);
                idle(GAP + 3);
                return;
            end
            idle(gap_len(rnd) - 1);
            drive_byte(pkt[i], d);
`ifdef LCB_RX_CHKSUM_EN
            sum = sum + pkt[i];
`endif
        end
`ifdef LCB_RX_CHKSUM_EN
        if (fault == F_TO) begin
            push_err(d + GAP + 1);
            idle(GAP + 3);
            return;
        end
        idle(gap_len(rnd) - 1);
        ck = 8'h00 - sum;
        if (fault == F_BAD) ck = ck + 8'(cut + 1);
        drive_byte(ck, d);
        if (fault == F_BAD) begin
            push_err(d + 1);
            idle(3);
            return;
        end
`endif
        q_start.push_back(d + 1);
        for (int i = 0; i < P; i++) q_xfer.push_back('{pkt[i], 5'(i), rq});
        done_pending++;
        if (fault == F_OVR) begin
            idle($urandom_range(0, 3));
            push_err(cyc + 1);
            drive_byte(8'($urandom), d);
        end
        wait_drain();
    endtask

    task automatic rand_pkt();
        for (int i = 0; i < P; i++) pkt[i] = 8'($urandom);
    endtask

    // Downstream ready pattern: held high, toggling, or random.
    initial begin
        iReady = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       iReady = 1'b1;
                1:       iReady = ~iReady;
                default: iReady = 1'($urandom);
            endcase
        end
    end

    // Monitor: compares everything the framer presents against the scoreboard queues.
    initial begin
        logic       prev_valid;
        logic       hold;
        logic [7:0] held_data;
        logic [4:0] held_idx;
        int         last_xfer_cyc;
        int         last_xfer_idx;
        xfer_t      e;
        prev_valid    = 1'b0;
        hold          = 1'b0;
        held_data     = 8'h00;
        held_idx      = 5'd0;
        last_xfer_cyc = -10;
        last_xfer_idx = -1;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_valid = 1'b0;
                hold       = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_valid", oValid, 1);
                    chk("hold_index_data", {oIndex, oData}, {held_idx, held_data});
                end
                if (oValid && !prev_valid) begin
                    if (q_start.size() == 0) chk("valid_unexpected", q_start.size(), 1);
                    else chk("valid_start_cycle", cyc, q_start.pop_front());
                end
                if (oValid && iReady) begin
                    if (q_xfer.size() == 0) begin
                        chk("xfer_unexpected", q_xfer.size(), 1);
                    end else begin
                        e = q_xfer.pop_front();
                        chk("xfer_data", oData, e.data);
                        chk("xfer_index", oIndex, e.idx);
                        chk("xfer_rqnum", oRqNum, e.rq);
                    end
                    last_xfer_cyc = cyc;
                    last_xfer_idx = int'(oIndex);
                end
                if (oPktDone) begin
                    chk("pktdone_expected", done_pending > 0, 1);
                    if (done_pending > 0) done_pending--;
                    chk("pktdone_cycle", cyc, last_xfer_cyc + 1);
                    chk("pktdone_last_index", last_xfer_idx, P - 1);
                    chk("pktdone_valid_low", oValid, 0);
                end
                if (oErr) begin
                    if (q_err_cnt.size() == 0) begin
                        chk("err_unexpected", q_err_cnt.size(), 1);
                    end else begin
                        chk("err_cycle", cyc, q_err_cyc.pop_front());
                        chk("err_count", oErrCnt, q_err_cnt.pop_front());
                    end
                end
                hold       = oValid && !iReady;
                held_data  = oData;
                held_idx   = oIndex;
                prev_valid = oValid;
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d;
        int r;
        int fault;
        reset  = 1'b0;
        iValid = 1'b0;
        iData  = 8'h00;
        iRqNum = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_oData", oData, 0);
        chk("reset_oIndex", oIndex, 0);
        chk("reset_oRqNum", oRqNum, 0);
        chk("reset_oValid", oValid, 0);
        chk("reset_oBusy", oBusy, 0);
        chk("reset_oPktDone", oPktDone, 0);
        chk("reset_oErr", oErr, 0);
        chk("reset_oErrCnt", oErrCnt, 0);
        reset = 1'b1;
        idle(2);

        // Known packet 01..0C, request 7, ready held high.
        rdy_mode = 0;
        for (int i = 0; i < P; i++) pkt[i] = 8'(i + 1);
        send_packet(F_OK, 0, 1'b0, 5'd7);
`ifdef LCB_RX_CHKSUM_EN
        // Same packet with the checksum off by one.
        send_packet(F_BAD, 0, 1'b0, 5'd7);
`endif
        // Truncated after five payload bytes, then a good packet.
        send_packet(F_TO, 5, 1'b0, 5'd3);
        rand_pkt();
        send_packet(F_OK, 0, 1'b1, 5'd9);

        // Ready toggling every cycle.
        rdy_mode = 1;
        rand_pkt();
        send_packet(F_OK, 0, 1'b0, 5'd12);

        // Randomized traffic.
        for (int n = 0; n < 30; n++) begin
            rdy_mode = $urandom_range(0, 2);
            rand_pkt();
            send_noise();
            r     = $urandom_range(0, 99);
            fault = F_OK;
            if (r < 15) fault = F_TO;
            else if (r < 25) fault = F_OVR;
`ifdef LCB_RX_CHKSUM_EN
            else if (r < 40) fault = F_BAD;
            send_packet(fault, $urandom_range(0, P), 1'b1, 5'($urandom));
`else
            send_packet(fault, $urandom_range(0, P - 1), 1'b1, 5'($urandom));
`endif
        end

        // Reset in the middle of a payload.
        rdy_mode = 2;
        rand_pkt();
        iRqNum = 5'd21;
        drive_byte(SYNC, d);
        iRqNum = 5'd0;
        for (int i = 0; i < 6; i++) begin
            idle(1);
            drive_byte(pkt[i], d);
        end
        #1 reset = 1'b0;
        #1;
        chk("midrst_oData", oData, 0);
        chk("midrst_oIndex", oIndex, 0);
        chk("midrst_oRqNum", oRqNum, 0);
        chk("midrst_oValid", oValid, 0);
        chk("midrst_oBusy", oBusy, 0);
        chk("midrst_oPktDone", oPktDone, 0);
        chk("midrst_oErr", oErr, 0);
        chk("midrst_oErrCnt", oErrCnt, 0);
        model_errcnt = 0;
        idle(2);
        reset = 1'b1;
        idle(2);
        rand_pkt();
        send_packet(F_OK, 0, 1'b1, 5'd17);

        // Drive the error counter into saturation and beyond.
        rdy_mode = 0;
        while (model_errcnt < 255) send_packet(F_TO, 0, 1'b0, 5'd1);
        repeat (3) send_packet(F_TO, 0, 1'b0, 5'd2);
        rand_pkt();
        send_packet(F_OK, 0, 1'b1, 5'd30);

        idle(5);
        chk("final_errcnt", oErrCnt, model_errcnt);
        chk("final_xfer_queue", q_xfer.size(), 0);
        chk("final_start_queue", q_start.size(), 0);
        chk("final_err_queue", q_err_cnt.size(), 0);
        chk("final_done_pending", done_pending, 0);
        chk("final_idle", oBusy, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcb_rx_framer.md
# lcb_rx_framer

Packet framer between a LCB RS-485 UART receiver and the LCB word writer that fills the ping-pong orbit memories. It hunts for a sync byte in the raw UART byte stream, collects a fixed-length payload into a local buffer, validates it (gap timeout, optional checksum), and only then drains the verified bytes downstream, tagged with the M8 request number that was current at sync. Corrupt or truncated packets never reach the memory path; they only bump an error counter.

## Interface
Parameters:
- SYNC_BYTE, 8'hA5, packet start marker
- PAYLOAD_BYTES, 12, payload length in bytes (1..31)
- GAP_CYCLES, 400, max clk cycles between bytes inside a packet (≥2)

Ports:
- clk  in  1  system clock (80 MHz domain)
- reset  in  1  asynchronous, active-low reset
- iData  in  8  received UART byte
- iValid  in  1  one-cycle strobe, iData valid
- iRqNum  in  5  current M8 request number
- oData  out  8  verified payload byte
- oIndex  out  5  byte position of oData in payload, 0-based
- oRqNum  out  5  request number latched at sync
- oValid  out  1  oData/oIndex valid
- iReady  in  1  downstream accepts byte (transfer = oValid & iReady)
- oBusy  out  1  high in any state except IDLE
- oPktDone  out  1  one-cycle pulse after last payload byte transferred
- oErr  out  1  one-cycle pulse on any packet error
- oErrCnt  out  8  saturating error count

## Operation
- States: IDLE, PAYLOAD, CHECK, DRAIN.
- IDLE: iValid with iData==SYNC_BYTE → latch iRqNum into oRqNum, clear byte count and running sum, → PAYLOAD. Other bytes discarded silently.
- PAYLOAD: each iValid stores byte at buf[count], adds to 8-bit sum (mod 256), count+1. After byte PAYLOAD_BYTES-1: → CHECK (macro on) or → DRAIN (macro off). SYNC_BYTE value inside payload is ordinary data.
- CHECK: next iValid is checksum; pass if (sum + byte) mod 256 == 0 → DRAIN, else error → IDLE.
- DRAIN: oValid=1, oData=buf[oIndex]; on each transfer oIndex+1; after transfer of index PAYLOAD_BYTES-1 → IDLE, oPktDone pulses. iValid bytes arriving in DRAIN are dropped and count as overrun error (state unchanged).
- Gap timer: in PAYLOAD/CHECK counts cycles since last accepted byte; reaching GAP_CYCLES without iValid → error → IDLE. iValid in the expiry cycle wins: byte accepted, timer restarts.
- Errors (checksum fail, timeout, overrun): oErr pulse, oErrCnt+1, holds at 255.

## Timing
- Reset values: oData 0, oIndex 0, oRqNum 0, oValid 0, oBusy 0, oPktDone 0, oErr 0, oErrCnt 0; state IDLE, buffer contents irrelevant.
- Sync accepted at edge N → oBusy=1 from N+1.
- Last validating byte (checksum or last payload) at edge M → oValid=1 from M+1; with iReady held high, bytes at M+1..M+PAYLOAD_BYTES, oPktDone and oValid=0 at M+PAYLOAD_BYTES+1.
- oValid/oData/oIndex stable while iReady=0; no bubble between consecutive transfers.
- oErr and state→IDLE registered in the cycle after the error event.
- Reset mid-packet: immediate return to IDLE, partial packet lost, no oErr, counter cleared.

## Configuration
- LCB_RX_CHKSUM_EN defined: CHECK state present, trailing checksum byte required and verified.
- Not defined: no checksum byte; DRAIN entered straight after last payload byte; CHECK and sum logic removed; checksum errors impossible.

## Structure
- Package lcb_rx_pkg: state enum, default SYNC_BYTE, byte/index/request-number width constants.
- One sub-module: lcb_rx_gap_timer (restart, enable, expiry pulse, GAP_CYCLES parameter).

## Test plan
- A5, bytes 01..0C, checksum B2 (LCB_RX_CHKSUM_EN), iReady=1, iRqNum=7 → 12 transfers 01..0C, oIndex 0..11, oRqNum 7, oPktDone once, oErrCnt 0.
- Same packet, checksum B3 → no oValid, oErr pulse, oErrCnt=1, IDLE.
- A5 then 5 bytes, then silence 400 cycles → oErr one cycle after expiry, oErrCnt+1; following valid packet framed correctly.
- Valid packet, iReady toggled 1/0 every cycle → bytes held stable while low, all 12 delivered in order, oPktDone after 12th.
- oErrCnt at 255, another bad packet → oErrCnt stays 255, oErr still pulses.
- Reset asserted at payload byte 6 → all outputs zero immediately; next full packet delivered normally.
